// File: rtl/mux_2_pkg.sv
// rtl/mux_2_pkg.sv - shared types and defaults for the two-input packet arbiter
package mux_2_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } arb_state_t;

   localparam int MUX_2_ARB_WIDTH_DEF = 8;

endpackage

// File: rtl/mux_2.sv
// rtl/mux_2.sv - single-bit 2:1 selection cell
module mux_2 (
   input  logic i0,
   input  logic i1,
   input  logic s,
   output logic y
);

   assign y = s ? i1 : i0;

endmodule

// File: rtl/mux_2_arb.sv
// rtl/mux_2_arb.sv - packet-locked round-robin arbiter over two sources with a registered output beat
module mux_2_arb
   import mux_2_pkg::*;
#(
   parameter int WIDTH = MUX_2_ARB_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i0_data,
   input  logic             i0_valid,
   input  logic             i0_last,
   output logic             i0_ready,
   input  logic [WIDTH-1:0] i1_data,
   input  logic             i1_valid,
   input  logic             i1_last,
   output logic             i1_ready,
   output logic             s,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             out_last,
   input  logic             out_ready
);

   arb_state_t       state;
   arb_state_t       state_next;
   logic             prio;
   logic             prio_next;
   logic             grant0;
   logic             grant1;
   logic             grant_sel;
   logic             free;
   logic             accept0;
   logic             accept1;
   logic             accept;
   logic             sel_last;
   logic [WIDTH-1:0] mux_data;

   // A locked state keeps its grant even while the owner idles, starving the other source.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      case (state)
         IDLE: begin
            if (i0_valid && i1_valid) begin
               grant0 = ~prio;
               grant1 = prio;
            end else if (i0_valid) begin
               grant0 = 1'b1;
            end else if (i1_valid) begin
               grant1 = 1'b1;
            end
         end
         LOCK0:   grant0 = 1'b1;
         LOCK1:   grant1 = 1'b1;
         default: begin
            grant0 = 1'b0;
            grant1 = 1'b0;
         end
      endcase
   end

   assign grant_sel = grant1;
   assign free      = ~out_valid | out_ready;
   assign i0_ready  = grant0 & free & rst_n;
   assign i1_ready  = grant1 & free & rst_n;
   assign accept0   = i0_ready & i0_valid;
   assign accept1   = i1_ready & i1_valid;
   assign accept    = accept0 | accept1;
   assign sel_last  = grant_sel ? i1_last : i0_last;

   always_comb begin
      state_next = state;
      prio_next  = prio;
      if (accept0) begin
         if (i0_last) begin
            state_next = IDLE;
            prio_next  = 1'b1;
         end else begin
            state_next = LOCK0;
         end
      end else if (accept1) begin
         if (i1_last) begin
            state_next = IDLE;
            prio_next  = 1'b0;
         end else begin
            state_next = LOCK1;
         end
      end
   end

   genvar k;
   generate
      for (k = 0; k < WIDTH; k++) begin : g_bit_mux
         mux_2 u_mux (
            .i0 (i0_data[k]),
            .i1 (i1_data[k]),
            .s  (grant_sel),
            .y  (mux_data[k])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         prio  <= 1'b0;
      end else begin
         state <= state_next;
         prio  <= prio_next;
      end
   end

   // Draining without a reload only clears valid; data, last and select keep the old beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         s         <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= mux_data;
         out_last  <= sel_last;
         s         <= grant_sel;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
